// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port memory.
// Round-robin on ties, one access per 3 cycles, range-checked stores.
//
// Ports:
//   Clk, Rst_n            clock, async active-low reset
//   i_req/i_addr          fetch request in; i_ack/i_rdata out
//   d_req/d_we/d_addr/d_wdata  data request in; d_ack/d_rdata out
//   err, busy             out-of-range strobe, non-idle flag
//   mem_addr/mem_wdata/mem_we  to memory; mem_rdata from memory
module mem_arbiter #(
  parameter int MEM_WORDS = 513,
  parameter int AW        = 32
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [31:0]   i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_ack,
  output logic [31:0]   d_rdata,
  output logic          err,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_we,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e        state_q;
  logic          last_d_q;
  logic          win_d_q;
  logic          we_q;
  logic          oor_q;
  logic          i_ack_q;
  logic          d_ack_q;
  logic          err_q;
  logic          busy_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic [31:0]   i_rdata_q;
  logic [31:0]   d_rdata_q;

  logic          gnt_i_d;
  logic [AW-1:0] addr_d;
  logic          we_d;
  logic [31:0]   wdata_d;
  logic          oor_d;

  // Fetch wins when alone, or on a tie when data won last.
  always_comb begin
    gnt_i_d = i_req & (~d_req | last_d_q);
    addr_d  = gnt_i_d ? i_addr : d_addr;
    we_d    = ~gnt_i_d & d_we;
    wdata_d = gnt_i_d ? 32'h0 : d_wdata;
    oor_d   = addr_d >= AW'(MEM_WORDS);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b1;
      win_d_q     <= 1'b0;
      we_q        <= 1'b0;
      oor_q       <= 1'b0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_req | d_req) begin
            state_q     <= ACCESS;
            win_d_q     <= ~gnt_i_d;
            last_d_q    <= ~gnt_i_d;
            we_q        <= we_d;
            oor_q       <= oor_d;
            busy_q      <= 1'b1;
            mem_addr_q  <= addr_d;
            mem_wdata_q <= wdata_d;
            mem_we_q    <= we_d & ~oor_d;
          end
        end
        ACCESS: begin
          state_q     <= RESP;
          mem_we_q    <= 1'b0;
          mem_wdata_q <= '0;
          i_ack_q     <= ~win_d_q;
          d_ack_q     <= win_d_q;
          err_q       <= oor_q;
          // Stores leave both read-data registers alone.
          if (!we_q) begin
            if (win_d_q) begin
              d_rdata_q <= oor_q ? 32'h0 : mem_rdata;
            end else begin
              i_rdata_q <= oor_q ? 32'h0 : mem_rdata;
            end
          end
        end
        RESP: begin
          state_q    <= IDLE;
          i_ack_q    <= 1'b0;
          d_ack_q    <= 1'b0;
          err_q      <= 1'b0;
          busy_q     <= 1'b0;
          mem_addr_q <= '0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural memory.
// Directed vectors; a negedge monitor pops expected responses.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int MW = 513;

  logic          Clk;
  logic          Rst_n;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [31:0]   i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_ack;
  logic [31:0]   d_rdata;
  logic          err;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic [31:0]   mem_rdata;

  mem_arbiter #(.MEM_WORDS(MW), .AW(AW)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_ack    (i_ack),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .err      (err),
    .busy     (busy),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [31:0] mem [0:MW-1];
  int          we_cnt;

  always_comb begin
    mem_rdata = 32'hDEADBEEF;
    if (mem_addr < AW'(MW)) mem_rdata = mem[mem_addr[9:0]];
  end

  always @(posedge Clk) begin
    if (mem_we) begin
      we_cnt = we_cnt + 1;
      if (mem_addr < AW'(MW)) mem[mem_addr[9:0]] <= mem_wdata;
    end
  end

  typedef struct {
    bit          port_d;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t sb[$];
  int   tests;
  int   failed;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(bit pd, logic [31:0] rd, bit e);
    exp_t x;
    x.port_d = pd;
    x.rdata  = rd;
    x.err    = e;
    sb.push_back(x);
  endtask

  always @(negedge Clk) begin
    if (Rst_n) begin
      if (i_ack && d_ack) chk("both_ack", 32'd1, 32'd0);
      if (err && !(i_ack || d_ack)) chk("stray_err", 32'd1, 32'd0);
      if (mem_we && mem_addr >= AW'(MW)) chk("oor_write", mem_addr, 32'd0);
      if (i_ack || d_ack) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", {30'd0, d_ack, i_ack}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_port", {31'd0, d_ack}, {31'd0, e.port_d});
          chk("err", {31'd0, err}, {31'd0, e.err});
          if (e.port_d) chk("d_rdata", d_rdata, e.rdata);
          else          chk("i_rdata", i_rdata, e.rdata);
        end
      end
    end
  end

  task automatic reset_outs(string tag);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_acks"}, {30'd0, i_ack, d_ack}, 32'd0);
    chk({tag, "_err_busy"}, {30'd0, err, busy}, 32'd0);
    chk({tag, "_i_rdata"}, i_rdata, 32'd0);
    chk({tag, "_d_rdata"}, d_rdata, 32'd0);
  endtask

  // One transaction from IDLE; ack must come two edges after raise.
  task automatic access(bit pd, bit we, logic [31:0] a,
                        logic [31:0] wd, logic [31:0] exp_rd,
                        bit exp_err);
    int n;
    int w0;
    bit got;
    @(negedge Clk);
    push(pd, exp_rd, exp_err);
    w0 = we_cnt;
    if (pd) begin
      d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    end else begin
      i_req = 1'b1; i_addr = a;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 8) begin
      @(posedge Clk); #1;
      n++;
      if ((pd && d_ack) || (!pd && i_ack)) got = 1'b1;
    end
    i_req = 1'b0;
    d_req = 1'b0;
    chk("latency", n, got ? 32'd2 : 32'd99);
    chk("write_count", we_cnt - w0,
        (pd && we && a < 32'(MW)) ? 32'd1 : 32'd0);
    @(posedge Clk);
  endtask

  initial begin
    tests = 0; failed = 0; we_cnt = 0;
    for (int k = 0; k < MW; k++) mem[k] = 32'h1000_0000 | k;
    mem[128] = 32'h8c030000;
    mem[7]   = 32'h7777_0007;
    mem[10]  = 32'hAAAA_0001;
    mem[20]  = 32'hBBBB_0002;
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
    d_wdata = 0; Rst_n = 0;
    #12;
    reset_outs("rst");
    @(negedge Clk); Rst_n = 1;

    access(0, 0, 128, 0, 32'h8c030000, 0);
    access(1, 1, 6, 32'h0000000D, 32'h0, 0);
    chk("mem6", mem[6], 32'h0000000D);
    access(1, 0, 6, 0, 32'h0000000D, 0);
    access(1, 1, 600, 32'h5555_AAAA, 32'h0000000D, 1);
    access(0, 0, 513, 0, 32'h0, 1);

    // Reset while a store to 7 is in ACCESS.
    @(negedge Clk);
    d_req = 1; d_we = 1; d_addr = 7; d_wdata = 32'h1234_5678;
    @(posedge Clk); #1;
    chk("store7_we", {31'd0, mem_we}, 32'd1);
    #2 Rst_n = 0;
    #1;
    reset_outs("midrst");
    d_req = 0; d_we = 0;
    @(negedge Clk); @(negedge Clk);
    chk("mem7", mem[7], 32'h7777_0007);
    Rst_n = 1;

    // Tie from reset: I, D, I, D every 3 cycles.
    begin
      int cyc, tot, ic, dc;
      int exp_c[4] = '{2, 5, 8, 11};
      @(negedge Clk);
      push(0, 32'hAAAA_0001, 0);
      push(1, 32'hBBBB_0002, 0);
      push(0, 32'hAAAA_0001, 0);
      push(1, 32'hBBBB_0002, 0);
      i_req = 1; i_addr = 10;
      d_req = 1; d_we = 0; d_addr = 20;
      cyc = 0; tot = 0; ic = 0; dc = 0;
      while (tot < 4 && cyc < 20) begin
        @(posedge Clk); #1;
        cyc++;
        if (i_ack || d_ack) begin
          chk("tie_cycle", cyc, exp_c[tot]);
          tot++;
          if (i_ack) begin ic++; if (ic == 2) i_req = 0; end
          if (d_ack) begin dc++; if (dc == 2) d_req = 0; end
        end
      end
      chk("tie_acks", tot, 32'd4);
      i_req = 0; d_req = 0;
      @(posedge Clk);
    end

    // Data request raised during a fetch's ACCESS.
    begin
      int n;
      bit got;
      @(negedge Clk);
      push(0, 32'h8c030000, 0);
      push(1, 32'h0000000D, 0);
      i_req = 1; i_addr = 128;
      @(posedge Clk); #1;
      d_req = 1; d_we = 0; d_addr = 6;
      n = 0; got = 0;
      while (!got && n < 10) begin
        @(posedge Clk); #1;
        n++;
        if (i_ack) i_req = 0;
        if (d_ack) got = 1;
      end
      d_req = 0;
      chk("late_d_cycle", n, 32'd4);
      @(posedge Clk);
    end

    repeat (3) @(negedge Clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected done");
    $fatal(1, "timeout");
  end

endmodule
